// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared state encoding, default timing and event types for the key classifier
package key_evt_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRESS1    = 3'd1;
    localparam logic [STATE_W-1:0] ST_LONG_HOLD = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_GAP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_PRESS2    = 3'd4;

    // Defaults assume a 50 MHz clock: 1 s long press, 250 ms gap, 200 ms repeat
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_GAP_CYCLES    = 12_500_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int DEF_CNT_W         = 26;

    localparam int EVT_CNT_W = 8;

    typedef struct packed {
        logic short_press;
        logic long_press;
        logic repeat_press;
        logic double_click;
    } key_evt_t;

    function automatic logic any_event(input key_evt_t evt);
        return evt.short_press | evt.long_press | evt.repeat_press | evt.double_click;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - rise/fall detector for a debounced level, previous value resets high
module key_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    // Reset high so a level already asserted through reset never looks like a fresh press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_d <= 1'b1;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/key_event_classifier.sv
// rtl/key_event_classifier.sv - classifies key gestures into short/long/repeat/double-click pulses
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_stable,
    output logic                 short_press,
    output logic                 long_press,
    output logic                 repeat_press,
    output logic                 double_click,
    output logic [EVT_CNT_W-1:0] evt_cnt,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic                 rise;
    logic                 fall;
    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_nxt;
    logic [CNT_W-1:0]     timer;
    logic [CNT_W-1:0]     timer_nxt;
    key_evt_t             evt_nxt;
    key_evt_t             evt_q;

    key_edge_det u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (key_stable),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        evt_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_PRESS1;
                    timer_nxt = '0;
                end
            end
            ST_PRESS1: begin
                // Release takes priority over a long terminal landing on the same edge
                if (fall) begin
                    state_nxt = ST_WAIT_GAP;
                    timer_nxt = '0;
                end else if (key_stable) begin
                    if (timer == LONG_TC) begin
                        evt_nxt.long_press = 1'b1;
                        state_nxt          = ST_LONG_HOLD;
                        timer_nxt          = '0;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
            end
            ST_LONG_HOLD: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end else if (key_stable && timer == REPEAT_TC) begin
                    evt_nxt.repeat_press = 1'b1;
                    timer_nxt            = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_WAIT_GAP: begin
                // A second press on the timeout edge still counts as a double click
                if (rise) begin
                    state_nxt = ST_PRESS2;
                    timer_nxt = '0;
                end else if (timer == GAP_TC) begin
                    evt_nxt.short_press = 1'b1;
                    state_nxt           = ST_IDLE;
                    timer_nxt           = '0;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    evt_nxt.double_click = 1'b1;
                    state_nxt            = ST_IDLE;
                    timer_nxt            = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            evt_q   <= '0;
            evt_cnt <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            evt_q <= evt_nxt;
            if (any_event(evt_nxt)) begin
                evt_cnt <= evt_cnt + EVT_CNT_W'(1);
            end
        end
    end

    assign short_press  = evt_q.short_press;
    assign long_press   = evt_q.long_press;
    assign repeat_press = evt_q.repeat_press;
    assign double_click = evt_q.double_click;
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_key_event_classifier.sv
// tb/tb_key_event_classifier.sv - directed self-checking bench for key_event_classifier
module tb_key_event_classifier;

    localparam logic [3:0] P_NONE   = 4'b0000;
    localparam logic [3:0] P_SHORT  = 4'b1000;
    localparam logic [3:0] P_LONG   = 4'b0100;
    localparam logic [3:0] P_REPEAT = 4'b0010;
    localparam logic [3:0] P_DOUBLE = 4'b0001;

    logic       clk;
    logic       rst;
    logic       key_stable;
    logic       short_press;
    logic       long_press;
    logic       repeat_press;
    logic       double_click;
    logic [7:0] evt_cnt;
    logic       busy;

    int         vectors;
    int         miscompares;
    logic [7:0] exp_cnt;

    key_event_classifier #(
        .LONG_CYCLES   (20),
        .GAP_CYCLES    (8),
        .REPEAT_CYCLES (5),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_stable   (key_stable),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_press (repeat_press),
        .double_click (double_click),
        .evt_cnt      (evt_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input logic [3:0] exp_p, input string tag);
        logic [3:0] obs;
        obs = {short_press, long_press, repeat_press, double_click};
        vectors++;
        assert (obs === exp_p) else begin
            miscompares++;
            $error("FAIL %s pulses observed=%b expected=%b", tag, obs, exp_p);
        end
        vectors++;
        assert (evt_cnt === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s evt_cnt observed=%0d expected=%0d", tag, evt_cnt, exp_cnt);
        end
    endtask

    task automatic check_busy(input logic exp_b, input string tag);
        vectors++;
        assert (busy === exp_b) else begin
            miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, exp_b);
        end
    endtask

    // Apply key level for one clock edge, then check the registered outputs
    task automatic step(input logic k, input logic [3:0] exp_p, input string tag);
        key_stable = k;
        @(negedge clk);
        if (exp_p != P_NONE) exp_cnt = exp_cnt + 8'd1;
        check_out(exp_p, tag);
    endtask

    task automatic hold(input logic k, input int n, input string tag);
        for (int i = 0; i < n; i++) step(k, P_NONE, tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 8'd0;
        rst         = 1'b1;
        key_stable  = 1'b0;
        repeat (3) @(negedge clk);
        check_out(P_NONE, "reset_state");
        check_busy(1'b0, "reset_busy");
        rst = 1'b0;
        hold(1'b0, 3, "post_reset_idle");
        check_busy(1'b0, "post_reset_busy");

        // Short press: 5 high, release, short 8 edges after the release edge
        hold(1'b1, 5, "short_hold");
        check_busy(1'b1, "short_busy");
        hold(1'b0, 8, "short_gap");
        step(1'b0, P_SHORT, "short_pulse");
        hold(1'b0, 11, "short_after");
        check_busy(1'b0, "short_idle_busy");

        // Long press held 32 edges: long at T0+20, repeat at T0+25 and T0+30
        hold(1'b1, 20, "long_pre");
        step(1'b1, P_LONG, "long_pulse");
        hold(1'b1, 4, "long_rep_gap1");
        step(1'b1, P_REPEAT, "repeat_pulse1");
        hold(1'b1, 4, "long_rep_gap2");
        step(1'b1, P_REPEAT, "repeat_pulse2");
        hold(1'b1, 1, "long_tail");
        hold(1'b0, 12, "long_release");
        check_busy(1'b0, "long_idle_busy");

        // Double click: press 3, release 4, press 3, release
        hold(1'b1, 3, "dbl_p1");
        hold(1'b0, 4, "dbl_gap");
        hold(1'b1, 3, "dbl_p2");
        step(1'b0, P_DOUBLE, "dbl_pulse");
        hold(1'b0, 12, "dbl_after");

        // Second press lands exactly on the gap terminal edge
        hold(1'b1, 2, "edge_p1");
        hold(1'b0, 8, "edge_gap");
        hold(1'b1, 3, "edge_p2");
        check_busy(1'b1, "edge_press2_busy");
        step(1'b0, P_DOUBLE, "edge_dbl_pulse");
        hold(1'b0, 12, "edge_after");

        // Reset mid-PRESS1 with key held: nothing until a fresh press
        hold(1'b1, 5, "rst_pre");
        check_busy(1'b1, "rst_pre_busy");
        rst = 1'b1;
        #1;
        exp_cnt = 8'd0;
        check_out(P_NONE, "rst_async_clear");
        check_busy(1'b0, "rst_async_busy");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 30, "rst_held");
        check_busy(1'b0, "rst_held_busy");
        hold(1'b0, 10, "rst_release");
        check_busy(1'b0, "rst_release_busy");
        hold(1'b1, 2, "rst_fresh");
        check_busy(1'b1, "rst_fresh_busy");
        hold(1'b0, 8, "rst_fresh_gap");
        step(1'b0, P_SHORT, "rst_fresh_short");
        hold(1'b0, 2, "rst_fresh_after");

        // Counter wrap over 256 short gestures from a cleared counter
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        hold(1'b0, 2, "wrap_start");
        for (int g = 1; g <= 256; g++) begin
            hold(1'b1, 1, "wrap_press");
            hold(1'b0, 8, "wrap_gap");
            step(1'b0, P_SHORT, "wrap_short");
            if (g == 255) begin
                vectors++;
                assert (evt_cnt === 8'd255) else begin
                    miscompares++;
                    $error("FAIL wrap_255 evt_cnt observed=%0d expected=255", evt_cnt);
                end
            end
            if (g == 256) begin
                vectors++;
                assert (evt_cnt === 8'd0) else begin
                    miscompares++;
                    $error("FAIL wrap_256 evt_cnt observed=%0d expected=0", evt_cnt);
                end
            end
        end
        hold(1'b0, 3, "wrap_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
